// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out operand loader.
package sipo_pkg;

  typedef enum logic {
    SIPO_SHIFT = 1'b0,
    SIPO_FULL  = 1'b1
  } sipo_state_e;

  // Counter width able to represent 0..w.
  function automatic int unsigned sipo_cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready stream register with load enable; holds the parallel word.
module sipo_out_reg #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_loader.sv
// Serial-in/parallel-out operand loader: LSB-first shift register feeding a
// double-buffered output latch, valid/ready on both sides.
module sipo_loader
  import sipo_pkg::*;
#(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ser_valid_i,
  output logic             ser_ready_o,
  input  logic             ser_data_i,
  output logic             par_valid_o,
  input  logic             par_ready_i,
  output logic [Width-1:0] par_data_o
);

  localparam int unsigned CntW = sipo_cnt_width(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  sipo_state_e      state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] sr_q;
  logic             accept;
  logic             transfer;
  logic             latch_free;

  assign latch_free = !par_valid_o || par_ready_i;

  // clr_i overrides everything, including a pending FULL transfer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ser_ready_o = 1'b0;
    accept      = 1'b0;
    transfer    = 1'b0;
    if (clr_i) begin
      state_d = SIPO_SHIFT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        SIPO_SHIFT: begin
          ser_ready_o = 1'b1;
          accept      = ser_valid_i;
          if (ser_valid_i) begin
            if (cnt_q == CntLast) begin
              cnt_d   = '0;
              state_d = SIPO_FULL;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        SIPO_FULL: begin
          if (latch_free) begin
            transfer = 1'b1;
            state_d  = SIPO_SHIFT;
          end
        end
        default: state_d = SIPO_SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SIPO_SHIFT;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        sr_q <= {ser_data_i, sr_q[Width-1:1]};
      end
    end
  end

  sipo_out_reg #(
    .Width(Width)
  ) u_out_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (transfer),
    .data_i  (sr_q),
    .valid_o (par_valid_o),
    .ready_i (par_ready_i),
    .data_o  (par_data_o)
  );

endmodule

// File: tb/tb_sipo_loader.sv
// Scoreboard bench for sipo_loader: directed scenarios plus randomized gaps/back-pressure.
module tb_sipo_loader;

  localparam int unsigned W = 4;

  logic         clk_i;
  logic         rst_ni;
  logic         clr_i;
  logic         ser_valid_i;
  logic         ser_ready_o;
  logic         ser_data_i;
  logic         par_valid_o;
  logic         par_ready_i;
  logic [W-1:0] par_data_o;

  sipo_loader #(
    .Width(W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (clr_i),
    .ser_valid_i (ser_valid_i),
    .ser_ready_o (ser_ready_o),
    .ser_data_i  (ser_data_i),
    .par_valid_o (par_valid_o),
    .par_ready_i (par_ready_i),
    .par_data_o  (par_data_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_words  = 0;
  logic rand_rdy = 1'b0;

  // Reference model: bits accepted so far, and complete words awaiting consumption.
  logic        part_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rand_rdy) par_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic model_accept(input logic b);
    logic [31:0] w;
    part_q.push_back(b);
    if (part_q.size() == W) begin
      w = '0;
      for (int i = 0; i < int'(W); i++) w = w | (32'(part_q[i]) << i);
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  task automatic send_bit(input logic b);
    logic rdy;
    logic ok;
    ok          = 1'b0;
    ser_valid_i = 1'b1;
    ser_data_i  = b;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      rdy = ser_ready_o;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    ser_valid_i = 1'b0;
    if (ok) model_accept(b);
    else check("ser_ready_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit gaps);
    logic [W-1:0] v;
    v = w;
    for (int i = 0; i < int'(W); i++) begin
      if (gaps) begin
        for (int g = 0; g < 8; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          tick();
        end
      end
      send_bit(v[i]);
    end
  endtask

  // Monitor: every consumed word must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (rst_ni && par_valid_o && par_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL word: got %0h, expected no word (t=%0t)", par_data_o, $time);
      end else begin
        check("word", 32'(par_data_o), exp_q.pop_front());
        n_words++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got running, expected finished");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst_ni      = 1'b0;
    clr_i       = 1'b0;
    ser_valid_i = 1'b0;
    ser_data_i  = 1'b0;
    par_ready_i = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ser_ready", 32'(ser_ready_o), 32'd1);
    check("rst_par_valid", 32'(par_valid_o), 32'd0);
    check("rst_par_data",  32'(par_data_o),  32'd0);
    rst_ni = 1'b1;
    tick();

    // First word 1,0,1,1 and one-cycle latency
    par_ready_i = 1'b1;
    send_word(4'b1101, 1'b0);
    check("lat_pre_valid", 32'(par_valid_o), 32'd0);
    tick();
    check("lat_valid", 32'(par_valid_o), 32'd1);
    check("lat_data",  32'(par_data_o),  32'hD);
    repeat (2) tick();

    // Back-pressure, then same-cycle consume and refill
    par_ready_i = 1'b0;
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    tick();
    check("bp_ready",  32'(ser_ready_o), 32'd0);
    check("bp_hold",   32'(par_data_o),  32'hA);
    repeat (3) tick();
    check("bp_ready_held", 32'(ser_ready_o), 32'd0);
    par_ready_i = 1'b1;
    tick();
    par_ready_i = 1'b0;
    check("refill_valid", 32'(par_valid_o), 32'd1);
    check("bp_data",      32'(par_data_o),  32'h5);
    check("bp_resume",    32'(ser_ready_o), 32'd1);

    // Clear after 2 bits of 4'hF; latch word 5 must survive
    send_bit(1'b1);
    send_bit(1'b1);
    clr_i       = 1'b1;
    ser_valid_i = 1'b1;
    ser_data_i  = 1'b1;
    @(negedge clk_i);
    check("clr_ready", 32'(ser_ready_o), 32'd0);
    tick();
    clr_i       = 1'b0;
    ser_valid_i = 1'b0;
    part_q.delete();
    check("clr_keep_valid", 32'(par_valid_o), 32'd1);
    send_word(4'h3, 1'b0);
    tick();
    check("clr_keep_data", 32'(par_data_o), 32'h5);
    par_ready_i = 1'b1;
    repeat (6) tick();
    check("clr_drain", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-word with a word pending in the latch
    par_ready_i = 1'b0;
    send_word(4'h9, 1'b0);
    tick();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(par_valid_o), 32'd0);
    check("mid_rst_data",  32'(par_data_o),  32'd0);
    check("mid_rst_ready", 32'(ser_ready_o), 32'd1);
    exp_q.delete();
    part_q.delete();
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    par_ready_i = 1'b1;
    send_word(4'h6, 1'b0);
    repeat (3) tick();
    check("mid_rst_resume", 32'(exp_q.size()), 32'd0);

    // Random serial gaps and random consumer back-pressure
    base     = n_words;
    rand_rdy = 1'b1;
    for (int k = 0; k < 100; k++) send_word(W'($urandom_range(0, 15)), 1'b1);
    rand_rdy    = 1'b0;
    par_ready_i = 1'b1;
    repeat (20) tick();
    check("gap_drain", 32'(exp_q.size()), 32'd0);
    check("gap_count", 32'(n_words - base), 32'd100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sipo_loader.md
# sipo_loader

Serial-in/parallel-out operand loader: shifts `Width` bits in LSB-first over a valid/ready serial port, then transfers the word into a double-buffered output latch with a valid/ready parallel port. It is the register stage directly upstream of the `a22o`-class merge cells. With `Width = 4`, `par_data_o[1:0]` drives `a_i` and `par_data_o[3:2]` drives `b_i`, so operands stay stable while the next word shifts in. Its behaviour corresponds to a 74HC595-style shift register plus output latch, built from the library's flop cells.

## Interface
- `Width`, 4, number of bits per word (≥ 2).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  reset, asynchronous and active-low.
- `clr_i`  in  1  synchronous clear of the shift path (counter and FSM). The output latch is not affected.
- `ser_valid_i`  in  1  serial bit offered.
- `ser_ready_o`  out  1  loader accepts a serial bit.
- `ser_data_i`  in  1  serial bit; the first accepted bit becomes bit 0.
- `par_valid_o`  out  1  `par_data_o` holds an unconsumed word.
- `par_ready_i`  in  1  consumer takes the word.
- `par_data_o`  out  `Width`  latched word, stable while `par_valid_o` is high and not yet consumed.

## Operation
- **Shift register `sr`, `Width` bits:** on each accepted bit (`ser_valid_i && ser_ready_o`), `sr <= {ser_data_i, sr[Width-1:1]}`. After `Width` accepts, bit 0 is the first-received bit.
- **Bit counter `cnt`:** width `$clog2(Width+1)`, range 0..`Width-1` in SHIFT.
- **FSM states:** SHIFT, FULL.
  - SHIFT: `ser_ready_o = 1`. On accept, `cnt++`. On the accept with `cnt == Width-1`: `cnt <= 0`, go to FULL.
  - FULL: `ser_ready_o = 0`. When the latch is free, copy `sr` to the latch and go to SHIFT.
  - The latch is free when `!par_valid_o || par_ready_i` (same-cycle consume and refill is allowed).
- **Latch:**
  - `par_valid_o` sets on transfer.
  - `par_valid_o` clears on `par_ready_i` when no transfer happens in the same cycle.
  - `par_data_o` changes only on transfer.
- **`clr_i`:** forces SHIFT and `cnt = 0`. A partial word or a pending FULL word is discarded. A serial bit offered in the same cycle is not accepted: `ser_ready_o` is low while `clr_i` is high. The latch keeps its word and its valid flag.
- **Reset:** state SHIFT, `cnt = 0`, `sr = 0`, `par_data_o = 0`, `par_valid_o = 0`. Consequently `ser_ready_o = 1` as soon as `rst_ni` is high.
- **Reset mid-word:** all progress is lost, with no spurious `par_valid_o`.
- **`ser_valid_i` low:** holds `sr` and `cnt` with no timeout.

## Timing
- **Latency:** last bit accepted at edge N → transfer at edge N+1 → `par_valid_o` high after N+1 (1 cycle). This holds when the latch is free; otherwise FULL persists until it is.
- **Throughput:** one word per `Width+1` cycles at full serial rate. The consumer may take a word every cycle.
- **Outputs:**
  - `ser_ready_o` is purely a function of state and `clr_i` (no path from `ser_valid_i`).
  - `par_valid_o` and `par_data_o` are registered.
- **Back-pressure:** while FULL and the latch is held, `ser_ready_o` stays 0 indefinitely. No serial bit is dropped; `ser_data_i` is not sampled.
- **Async reset:** assertion clears all flops immediately. Deassertion is synchronised externally.

## Structure
- **Package `sipo_pkg`:** FSM state enum (`SIPO_SHIFT`, `SIPO_FULL`) and the counter-width helper function.
- **Sub-module `sipo_out_reg`:** the latch, a one-entry valid/ready stream register with load-enable and async active-low reset.
- **Top level:** shift register, counter, FSM, and the `clr_i` gating.

## Test plan
- **Reset values:** hold `rst_ni = 0` and check all outputs are at their reset values (`ser_ready_o = 1`, `par_valid_o = 0`, `par_data_o = 0`). Release reset, shift in bits 1,0,1,1 with `par_ready_i = 1`. Require `par_data_o = 4'b1101` and `par_valid_o` high exactly 1 cycle after the 4th accept.
- **Back-pressure:** `par_ready_i = 0`. Shift 4'hA, then 4'h5. Require `ser_ready_o = 0` after the 8th accept with 4'hA still on `par_data_o`. Raise `par_ready_i` for one cycle. Require `par_data_o = 4'h5` one cycle later.
- **Gaps:** random `ser_valid_i` gaps (50 % duty) over 100 words. Check words against a reference queue; no loss or duplication.
- **Clear:** pulse `clr_i` after 2 bits of 4'hF. Then shift 4'h3. Require the only new word to be 4'h3, and that a latch word already present is retained through the clear.
- **Reset mid-operation:** drop `rst_ni` asynchronously after the 3rd bit, with a word pending in the latch. Require `par_valid_o = 0` immediately and the next full word delivered intact.
- **Same-cycle consume and refill:** transfer and `par_ready_i` in the same cycle. Require `par_valid_o` to stay 1 with the new data and no bubble.
